// File: rtl/io_out_sched_pkg.sv
// io_out_sched_pkg: shared definitions for the buffered output-port scheduler.
// Contents: FSM state encoding and the {addr, data} entry-width helper.
// Imported by io_out_sched and io_out_sched_fifo.
package io_out_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Width of one queued entry: port address followed by the data word.
  function automatic int entry_w(input int nuioou, input int nubits);
    return $clog2(nuioou) + nubits;
  endfunction

endpackage

// File: rtl/io_out_sched_fifo.sv
// io_out_sched_fifo: circular buffer of DEPTH entries, combinational head.
// Ports: clk/rst, push + wdata write at the tail, pop advances the head,
//        rdata is the head entry, empty from the occupancy count.
module io_out_sched_fifo
  import io_out_sched_pkg::*;
#(
  parameter int W     = 17,
  parameter int DEPTH = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = next_ptr(wptr_q);
    if (pop)  rptr_d = next_ptr(rptr_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/io_out_sched.sv
// io_out_sched: buffers core output strobes and drains them in program order
// to NUIOOU peripherals over per-port valid/ready.
// Ports: out_en/addr_out/io_out in; p_data/p_valid/p_ready per-port handshake;
//        level/full/ovf status, ovf_clr clears the sticky overflow flag.
module io_out_sched
  import io_out_sched_pkg::*;
#(
  parameter int NUBITS = 16,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      out_en,
  input  logic [$clog2(NUIOOU)-1:0] addr_out,
  input  logic [NUBITS-1:0]         io_out,
  output logic [NUBITS-1:0]         p_data,
  output logic [NUIOOU-1:0]         p_valid,
  input  logic [NUIOOU-1:0]         p_ready,
  output logic [$clog2(FDEPTH):0]   level,
  output logic                      full,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int AW = $clog2(NUIOOU);
  localparam int LW = $clog2(FDEPTH) + 1;
  localparam int EW = entry_w(NUIOOU, NUBITS);

  state_e            state_q, state_d;
  logic [AW-1:0]     out_addr_q, out_addr_d;
  logic [NUBITS-1:0] out_data_q, out_data_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;

  logic          hs, push_ok;
  logic          fifo_push, fifo_pop, fifo_empty;
  logic [EW-1:0] fifo_rdata;

  // Out-of-range addresses match no port, so they present no valid at all.
  always_comb begin
    for (int k = 0; k < NUIOOU; k++) begin
      p_valid[k] = (state_q == ST_SEND) && (out_addr_q == AW'(k));
    end
  end

  // An entry with no valid port is retired in one cycle as if handshaken.
  assign hs      = (state_q == ST_SEND) && ((|(p_valid & p_ready)) || !(|p_valid));
  assign push_ok = out_en && ((level_q < LW'(FDEPTH)) || hs);

  // Pushes bypass the queue only when the output register is about to be free
  // and nothing older is waiting.
  assign fifo_push = push_ok && (state_q == ST_SEND) && !(hs && fifo_empty);
  assign fifo_pop  = hs && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    level_d    = level_q + LW'(push_ok) - LW'(hs);
    ovf_d      = ovf_q;

    if (ovf_clr)            ovf_d = 1'b0;
    if (out_en && !push_ok) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (push_ok) begin
          out_addr_d = addr_out;
          out_data_d = io_out;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (!fifo_empty) begin
            {out_addr_d, out_data_d} = fifo_rdata;
          end else if (push_ok) begin
            out_addr_d = addr_out;
            out_data_d = io_out;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_addr_q <= '0;
      out_data_q <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
    end
  end

  io_out_sched_fifo #(
    .W     (EW),
    .DEPTH (FDEPTH - 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({addr_out, io_out}),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

  assign p_data = out_data_q;
  assign level  = level_q;
  assign full   = (level_q == LW'(FDEPTH));
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_io_out_sched.sv
// tb_io_out_sched: directed bench for io_out_sched with an in-order scoreboard.
module tb_io_out_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_en = 1'b0;
  logic [0:0]  addr_out = '0;
  logic [15:0] io_out = '0;
  logic [15:0] p_data;
  logic [1:0]  p_valid;
  logic [1:0]  p_ready = 2'b00;
  logic [3:0]  level;
  logic        full;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Expected transfers as {onehot valid, data}, in program order.
  logic [17:0] sb[$];

  io_out_sched #(.NUBITS(16), .NUIOOU(2), .FDEPTH(8)) dut (
    .clk(clk), .rst(rst), .out_en(out_en), .addr_out(addr_out), .io_out(io_out),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
    .level(level), .full(full), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic a, input logic [15:0] d, input bit accept);
    out_en   = 1'b1;
    addr_out = a;
    io_out   = d;
    if (accept) sb.push_back({(a ? 2'b10 : 2'b01), d});
  endtask

  // Monitor: mid-cycle, a valid&ready pair is the transfer completing at the next edge.
  always @(negedge clk) begin
    if (!rst && ((p_valid & p_ready) != 2'b00)) begin
      logic [17:0] e;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_empty: observed transfer %0h/%0h expected none", p_valid, p_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("xfer_valid", 32'(p_valid), 32'(e[17:16]));
        check("xfer_data", 32'(p_data), 32'(e[15:0]));
      end
    end
  end

  initial begin
    int n;
    // Reset / idle
    #12;
    rst = 1'b0;
    step();
    check("rst_valid", 32'(p_valid), 0);
    check("rst_data", 32'(p_data), 0);
    check("rst_level", 32'(level), 0);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(ovf), 0);

    // Single write to port 1
    p_ready = 2'b11;
    write(1'b1, 16'h00A5, 1'b1);
    step();
    out_en = 1'b0;
    check("single_valid", 32'(p_valid), 32'h2);
    check("single_data", 32'(p_data), 32'h00A5);
    check("single_level", 32'(level), 1);
    step();
    check("single_idle_valid", 32'(p_valid), 0);
    check("single_idle_level", 32'(level), 0);

    // Back-to-back writes, alternating ports
    for (int i = 0; i < 4; i++) begin
      write(1'(i % 2), 16'(i + 1), 1'b1);
      step();
      check("b2b_valid", 32'(p_valid), ((i % 2) != 0) ? 32'h2 : 32'h1);
      check("b2b_data", 32'(p_data), 32'(i + 1));
      check("b2b_level", 32'(level), 1);
    end
    out_en = 1'b0;
    step();
    check("b2b_end_valid", 32'(p_valid), 0);
    check("b2b_end_level", 32'(level), 0);

    // Overflow: 9 writes into 8 entries with ready low
    p_ready = 2'b00;
    for (int i = 0; i < 9; i++) begin
      write(1'(i % 2), 16'(16'h10 + i), i < 8);
      step();
    end
    out_en = 1'b0;
    check("ovf_level", 32'(level), 8);
    check("ovf_full", 32'(full), 1);
    check("ovf_flag", 32'(ovf), 1);

    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);
    check("ovf_clr_level", 32'(level), 8);

    // Full with a simultaneous handshake: write accepted, level holds
    p_ready = 2'b11;
    write(1'b0, 16'h0099, 1'b1);
    step();
    out_en  = 1'b0;
    p_ready = 2'b00;
    check("full_hs_level", 32'(level), 8);
    check("full_hs_ovf", 32'(ovf), 0);
    check("full_hs_full", 32'(full), 1);

    // Drop together with ovf_clr: set wins
    write(1'b1, 16'h00EE, 1'b0);
    ovf_clr = 1'b1;
    step();
    out_en  = 1'b0;
    ovf_clr = 1'b0;
    check("drop_clr_ovf", 32'(ovf), 1);
    check("drop_clr_level", 32'(level), 8);

    // Drain; the monitor checks order
    p_ready = 2'b11;
    n = 0;
    while (level != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_level", 32'(level), 0);
    check("drain_sb", 32'(sb.size()), 0);

    // Reset mid-transfer
    p_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      write(1'(i), 16'(16'h30 + i), 1'b1);
      step();
    end
    out_en = 1'b0;
    check("pre_rst_valid", 32'(p_valid), 32'h1);
    check("pre_rst_level", 32'(level), 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(p_valid), 0);
    check("async_rst_level", 32'(level), 0);
    check("async_rst_full", 32'(full), 0);
    sb.delete();
    #2;
    rst = 1'b0;
    step();
    p_ready = 2'b11;
    write(1'b0, 16'h0077, 1'b1);
    step();
    out_en = 1'b0;
    check("post_rst_valid", 32'(p_valid), 32'h1);
    check("post_rst_data", 32'(p_data), 32'h0077);
    step();
    check("post_rst_idle", 32'(p_valid), 0);
    check("post_rst_level", 32'(level), 0);
    check("post_rst_sb", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
